// File: rtl/eth_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eth_gen_pkg
//  Description : Shared types and constants for the Ethernet test-frame
//                generator (FSM encoding, EtherType, payload layout).
//  Revision    : 1.0 - initial release
// ============================================================================
package eth_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_IFG  = 2'd2
    } state_t;

    localparam logic [15:0] c_ETHERTYPE     = 16'h88B5;
    localparam int unsigned c_PAYLOAD_START = 20;

    // Byte enables of the final beat for a frame whose length mod 8 is rem.
    function automatic logic [7:0] last_tkeep(input logic [2:0] rem);
        last_tkeep = (rem == 3'd0) ? 8'hFF : 8'((8'd1 << rem) - 8'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_frame_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : eth_frame_gen_if
//  Description : 64-bit AXI-Stream transmit bundle between generator and MAC.
//  Revision    : 1.0 - initial release
// ============================================================================
interface eth_frame_gen_if;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic        tready;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/eth_gen_beat_fmt.sv
`default_nettype none
// ============================================================================
//  Module      : eth_gen_beat_fmt
//  Description : Combinational formatter producing one 64-bit beat of a
//                broadcast test frame from beat index, length and sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_gen_beat_fmt
    import eth_gen_pkg::*;
#(
    parameter logic [47:0] P_SRC_MAC = 48'h000A_3501_0200
) (
    input  wire logic [10:0] i_beat,
    input  wire logic [14:0] i_len,
    input  wire logic [31:0] i_seq,
    output logic      [63:0] o_tdata,
    output logic      [7:0]  o_tkeep,
    output logic             o_tlast
);

    logic [11:0] w_nbeats;
    logic [15:0] w_len16;

    assign w_len16  = {1'b0, i_len};
    assign w_nbeats = 12'((w_len16 + 16'd7) >> 3);
    assign o_tlast  = ({1'b0, i_beat} == (w_nbeats - 12'd1));
    assign o_tkeep  = o_tlast ? last_tkeep(i_len[2:0]) : 8'hFF;

    function automatic logic [7:0] byte_at(input logic [13:0] k);
        logic [7:0] v;
        if (k < 14'd6) begin
            v = 8'hFF;
        end else if (k >= 14'(c_PAYLOAD_START)) begin
            v = k[7:0];
        end else begin
            case (k[4:0])
                5'd6:    v = P_SRC_MAC[47:40];
                5'd7:    v = P_SRC_MAC[39:32];
                5'd8:    v = P_SRC_MAC[31:24];
                5'd9:    v = P_SRC_MAC[23:16];
                5'd10:   v = P_SRC_MAC[15:8];
                5'd11:   v = P_SRC_MAC[7:0];
                5'd12:   v = c_ETHERTYPE[15:8];
                5'd13:   v = c_ETHERTYPE[7:0];
                5'd14:   v = w_len16[15:8];
                5'd15:   v = w_len16[7:0];
                5'd16:   v = i_seq[31:24];
                5'd17:   v = i_seq[23:16];
                5'd18:   v = i_seq[15:8];
                5'd19:   v = i_seq[7:0];
                default: v = 8'h00;
            endcase
        end
        return v;
    endfunction

    // Bytes at or beyond the frame length are forced to zero.
    always_comb begin
        o_tdata = '0;
        for (int j = 0; j < 8; j++) begin
            if (15'({i_beat, 3'(j)}) < i_len) begin
                o_tdata[j*8 +: 8] = byte_at({i_beat, 3'(j)});
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/eth_frame_gen.sv
`default_nettype none
// ============================================================================
//  Module      : eth_frame_gen
//  Description : AXI-Stream broadcast test-frame generator (fixed or sweeping
//                length, sequence-numbered, incrementing payload).
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_frame_gen
    import eth_gen_pkg::*;
#(
    parameter logic [7:0]  P_MIN_LENGTH = 8'd64,
    parameter logic [14:0] P_MAX_LENGTH = 15'd9600,
    parameter int          P_IFG_CYCLES = 4,
    parameter logic [47:0] P_SRC_MAC    = 48'h000A_3501_0200
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst,
    input  wire logic        i_enable,
    input  wire logic        i_sweep,
    input  wire logic [14:0] i_fixed_len,
    input  wire logic [31:0] i_frame_num,
    eth_frame_gen_if.master  axis,
    output logic      [31:0] o_frames_sent,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [14:0] c_MIN_LEN = 15'(P_MIN_LENGTH);

    state_t      state_q, state_d;
    logic [10:0] beat_q, beat_d;
    logic [14:0] len_q, len_d;
    logic [14:0] sweep_len_q, sweep_len_d;
    logic [31:0] seq_q, seq_d;
    logic [31:0] run_cnt_q, run_cnt_d;
    logic        run_done_q, run_done_d;
    logic [15:0] ifg_cnt_q, ifg_cnt_d;
    logic [31:0] frames_q, frames_d;
    logic        done_q, done_d;
    logic        tvalid_q, tvalid_d;
    logic [63:0] tdata_q, tdata_d;
    logic [7:0]  tkeep_q, tkeep_d;
    logic        tlast_q, tlast_d;

    logic        w_load;
    logic        w_decide;
    logic        w_hs;
    logic [14:0] w_fixed_clamped;
    logic [63:0] w_fmt_tdata;
    logic [7:0]  w_fmt_tkeep;
    logic        w_fmt_tlast;

    assign w_hs = tvalid_q & axis.tready;
    assign w_fixed_clamped = (i_fixed_len < c_MIN_LEN)    ? c_MIN_LEN    :
                             (i_fixed_len > P_MAX_LENGTH) ? P_MAX_LENGTH : i_fixed_len;

    eth_gen_beat_fmt #(
        .P_SRC_MAC (P_SRC_MAC)
    ) u_fmt (
        .i_beat  (beat_d),
        .i_len   (len_d),
        .i_seq   (seq_d),
        .o_tdata (w_fmt_tdata),
        .o_tkeep (w_fmt_tkeep),
        .o_tlast (w_fmt_tlast)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            len_q       <= '0;
            sweep_len_q <= c_MIN_LEN;
            seq_q       <= '0;
            run_cnt_q   <= '0;
            run_done_q  <= 1'b0;
            ifg_cnt_q   <= '0;
            frames_q    <= '0;
            done_q      <= 1'b0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tlast_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            len_q       <= len_d;
            sweep_len_q <= sweep_len_d;
            seq_q       <= seq_d;
            run_cnt_q   <= run_cnt_d;
            run_done_q  <= run_done_d;
            ifg_cnt_q   <= ifg_cnt_d;
            frames_q    <= frames_d;
            done_q      <= done_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            tlast_q     <= tlast_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        len_d       = len_q;
        sweep_len_d = sweep_len_q;
        seq_d       = seq_q;
        run_cnt_d   = run_cnt_q;
        run_done_d  = run_done_q;
        ifg_cnt_d   = ifg_cnt_q;
        frames_d    = frames_q;
        done_d      = 1'b0;
        tvalid_d    = tvalid_q;
        w_load      = 1'b0;
        w_decide    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!i_enable) begin
                    run_cnt_d  = '0;
                    run_done_d = 1'b0;
                end else if (!run_done_q) begin
                    state_d = ST_SEND;
                    len_d   = i_sweep ? sweep_len_q : w_fixed_clamped;
                    beat_d  = '0;
                end
            end
            ST_SEND: begin
                if (!tvalid_q) begin
                    // First frame of a run: beat 0 is loaded one cycle after the latch.
                    w_load   = 1'b1;
                    tvalid_d = 1'b1;
                end else if (w_hs) begin
                    if (tlast_q) begin
                        seq_d       = seq_q + 32'd1;
                        frames_d    = frames_q + 32'd1;
                        run_cnt_d   = run_cnt_q + 32'd1;
                        sweep_len_d = (sweep_len_q >= P_MAX_LENGTH) ? c_MIN_LEN
                                                                    : sweep_len_q + 15'd1;
                        tvalid_d    = 1'b0;
                        if (P_IFG_CYCLES == 0) begin
                            w_decide = 1'b1;
                        end else begin
                            state_d   = ST_IFG;
                            ifg_cnt_d = '0;
                        end
                    end else begin
                        beat_d = beat_q + 11'd1;
                        w_load = 1'b1;
                    end
                end
            end
            ST_IFG: begin
                if (ifg_cnt_q == 16'(P_IFG_CYCLES - 1)) begin
                    w_decide = 1'b1;
                end else begin
                    ifg_cnt_d = ifg_cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_decide) begin
            if ((i_frame_num != 32'd0) && (run_cnt_d == i_frame_num)) begin
                done_d     = 1'b1;
                run_done_d = 1'b1;
                state_d    = ST_IDLE;
            end else if (!i_enable) begin
                state_d = ST_IDLE;
            end else begin
                state_d  = ST_SEND;
                len_d    = i_sweep ? sweep_len_d : w_fixed_clamped;
                beat_d   = '0;
                w_load   = 1'b1;
                tvalid_d = 1'b1;
            end
        end
    end

    always_comb begin
        tdata_d = tdata_q;
        tkeep_d = tkeep_q;
        tlast_d = tlast_q;
        if (w_load) begin
            tdata_d = w_fmt_tdata;
            tkeep_d = w_fmt_tkeep;
            tlast_d = w_fmt_tlast;
        end else if (!tvalid_d) begin
            tdata_d = '0;
            tkeep_d = '0;
            tlast_d = 1'b0;
        end
    end

    assign axis.tvalid   = tvalid_q;
    assign axis.tdata    = tdata_q;
    assign axis.tkeep    = tkeep_q;
    assign axis.tlast    = tlast_q;
    assign o_frames_sent = frames_q;
    assign o_busy        = (state_q != ST_IDLE);
    assign o_done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_frame_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eth_frame_gen
//  Description : Directed self-checking bench for eth_frame_gen (default
//                instance plus a short-max, zero-IFG instance).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_frame_gen;

    logic        clk = 1'b0;
    logic        rst, en, en2, sweep, tready, sel;
    logic [14:0] fixed_len;
    logic [31:0] frame_num;
    logic [31:0] fs1, fs2;
    logic        busy1, busy2, done1, done2;

    int total = 0;
    int bad   = 0;

    logic [63:0] cap_b1, cap_last_d;
    logic [7:0]  cap_last_k;
    int          cap_nbeats;

    eth_frame_gen_if ax();
    eth_frame_gen_if ax2();

    assign ax.tready  = tready;
    assign ax2.tready = tready;

    always #5 clk = ~clk;

    eth_frame_gen #(
        .P_MIN_LENGTH (8'd64),
        .P_MAX_LENGTH (15'd9600),
        .P_IFG_CYCLES (4),
        .P_SRC_MAC    (48'h000A_3501_0200)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_enable      (en),
        .i_sweep       (sweep),
        .i_fixed_len   (fixed_len),
        .i_frame_num   (frame_num),
        .axis          (ax),
        .o_frames_sent (fs1),
        .o_busy        (busy1),
        .o_done        (done1)
    );

    eth_frame_gen #(
        .P_MIN_LENGTH (8'd64),
        .P_MAX_LENGTH (15'd66),
        .P_IFG_CYCLES (0),
        .P_SRC_MAC    (48'h000A_3501_0200)
    ) dut2 (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_enable      (en2),
        .i_sweep       (1'b1),
        .i_fixed_len   (15'd64),
        .i_frame_num   (32'd0),
        .axis          (ax2),
        .o_frames_sent (fs2),
        .o_busy        (busy2),
        .o_done        (done2)
    );

    wire        w_tv   = sel ? ax2.tvalid : ax.tvalid;
    wire [63:0] w_td   = sel ? ax2.tdata  : ax.tdata;
    wire [7:0]  w_tk   = sel ? ax2.tkeep  : ax.tkeep;
    wire        w_tl   = sel ? ax2.tlast  : ax.tlast;
    wire [31:0] w_fs   = sel ? fs2        : fs1;
    wire        w_done = sel ? done2      : done1;
    wire        w_busy = sel ? busy2      : busy1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_byte(input int k, input int len, input logic [31:0] seq);
        logic [47:0] mac;
        logic [15:0] l16;
        mac = 48'h000A_3501_0200;
        l16 = 16'(len);
        if (k >= len) return 8'h00;
        if (k < 6) return 8'hFF;
        case (k)
            6:  return mac[47:40];
            7:  return mac[39:32];
            8:  return mac[31:24];
            9:  return mac[23:16];
            10: return mac[15:8];
            11: return mac[7:0];
            12: return 8'h88;
            13: return 8'hB5;
            14: return l16[15:8];
            15: return l16[7:0];
            16: return seq[31:24];
            17: return seq[23:16];
            18: return seq[15:8];
            19: return seq[7:0];
            default: return 8'(k);
        endcase
    endfunction

    function automatic logic [7:0] exp_keep(input int len);
        if (len % 8 == 0) return 8'hFF;
        return 8'((1 << (len % 8)) - 1);
    endfunction

    // Consume one frame, checking every beat and stall stability.
    task automatic get_frame(input int len, input logic [31:0] seq, input bit rnd, input int drop_at);
        int b, errs, to;
        logic [63:0] hd, ed;
        logic [7:0]  hk, ek;
        bit stall, r, last;
        to = 0;
        while (!w_tv && to < 100) begin tick(); to++; end
        check("frame_start", 64'(w_tv), 64'd1);
        if (!w_tv) return;
        b = 0; errs = 0; stall = 0; hd = '0; hk = '0;
        while (1) begin
            if (b == drop_at) begin
                if (sel) en2 = 1'b0; else en = 1'b0;
            end
            for (int j = 0; j < 8; j++) ed[j*8 +: 8] = exp_byte(b*8 + j, len, seq);
            last = (b == (len + 7) / 8 - 1);
            ek   = last ? exp_keep(len) : 8'hFF;
            if (!w_tv || w_td !== ed || w_tk !== ek || w_tl !== last) errs++;
            if (stall && (w_td !== hd || w_tk !== hk)) errs++;
            if (b == 1) cap_b1 = w_td;
            cap_last_d = w_td; cap_last_k = w_tk;
            hd = w_td; hk = w_tk;
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tready = r;
            tick(); to++;
            if (r) begin
                if (last) break;
                b++; stall = 0;
            end else begin
                stall = 1;
            end
            if (to > 20000) begin errs++; break; end
        end
        tready = 1'b1;
        cap_nbeats = b + 1;
        check("frame_bytes", 64'(errs), 64'd0);
    endtask

    task automatic measure_gap(output int g);
        g = 0;
        while (!w_tv && g < 50) begin tick(); g++; end
    endtask

    task automatic watch(input int n, output int dn, output int tv);
        dn = 0; tv = 0;
        for (int i = 0; i < n; i++) begin
            if (w_done) dn++;
            if (w_tv) tv++;
            tick();
        end
    endtask

    initial begin
        int g, dn, tv, to;
        rst = 1'b1; en = 1'b0; en2 = 1'b0; sweep = 1'b0; tready = 1'b1; sel = 1'b0;
        fixed_len = 15'd64; frame_num = 32'd1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_tvalid", 64'(ax.tvalid), 64'd0);
        check("rst_busy", 64'(busy1), 64'd0);
        check("rst_frames", 64'(fs1), 64'd0);
        check("rst_done", 64'(done1), 64'd0);

        // Fixed 64, single-frame run, with start latency.
        en = 1'b1;
        tick();
        check("lat_edge_n", 64'(w_tv), 64'd0);
        tick();
        check("lat_edge_n1", 64'(w_tv), 64'd1);
        get_frame(64, 0, 0, -1);
        check("f64_beats", 64'(cap_nbeats), 64'd8);
        check("f64_keep", 64'(cap_last_k), 64'hFF);
        check("f64_lenfield", 64'(cap_b1[63:48]), 64'h4000);
        check("f64_frames", 64'(w_fs), 64'd1);
        watch(30, dn, tv);
        check("f64_done", 64'(dn), 64'd1);
        check("f64_no_restart", 64'(tv), 64'd0);
        check("f64_idle", 64'(w_busy), 64'd0);
        en = 1'b0; tick(); tick();

        // Fixed 65: partial last beat.
        fixed_len = 15'd65; en = 1'b1;
        get_frame(65, 1, 0, -1);
        check("f65_beats", 64'(cap_nbeats), 64'd9);
        check("f65_keep", 64'(cap_last_k), 64'h01);
        check("f65_lastdata", cap_last_d, 64'h40);
        check("f65_frames", 64'(w_fs), 64'd2);
        watch(10, dn, tv);
        en = 1'b0; tick(); tick();

        // Clamping: 10 -> 64, then 20000 -> 9600 on the next frame of the run.
        fixed_len = 15'd10; frame_num = 32'd2; en = 1'b1;
        get_frame(64, 2, 0, -1);
        check("clamp_lo_beats", 64'(cap_nbeats), 64'd8);
        fixed_len = 15'd20000;
        measure_gap(g);
        check("ifg_fixed", 64'(g), 64'd4);
        get_frame(9600, 3, 0, -1);
        check("clamp_hi_beats", 64'(cap_nbeats), 64'd1200);
        check("clamp_hi_keep", 64'(cap_last_k), 64'hFF);
        watch(10, dn, tv);
        check("clamp_done", 64'(dn), 64'd1);
        en = 1'b0; tick(); tick();

        // Random backpressure.
        fixed_len = 15'd100; frame_num = 32'd1; en = 1'b1;
        get_frame(100, 4, 1, -1);
        check("rnd_keep", 64'(cap_last_k), 64'h0F);
        check("rnd_frames", 64'(w_fs), 64'd5);
        watch(10, dn, tv);
        en = 1'b0; tick(); tick();

        // Enable dropped mid-frame in a continuous run.
        fixed_len = 15'd72; frame_num = 32'd0; en = 1'b1;
        get_frame(72, 5, 0, 3);
        check("drop_beats", 64'(cap_nbeats), 64'd9);
        watch(20, dn, tv);
        check("drop_no_done", 64'(dn), 64'd0);
        check("drop_no_more", 64'(tv), 64'd0);
        check("drop_idle", 64'(w_busy), 64'd0);
        check("drop_frames", 64'(w_fs), 64'd6);

        // Reset mid-frame, then a 3-frame sweep run from a clean state.
        sweep = 1'b1; frame_num = 32'd3; en = 1'b1;
        to = 0;
        while (!w_tv && to < 100) begin tick(); to++; end
        check("rst_run_start", 64'(w_tv), 64'd1);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("midrst_tvalid", 64'(w_tv), 64'd0);
        check("midrst_tlast", 64'(w_tl), 64'd0);
        check("midrst_frames", 64'(w_fs), 64'd0);
        rst = 1'b0;
        get_frame(64, 0, 0, -1);
        measure_gap(g);
        check("sweep_ifg1", 64'(g), 64'd4);
        get_frame(65, 1, 0, -1);
        check("sweep65_keep", 64'(cap_last_k), 64'h01);
        measure_gap(g);
        check("sweep_ifg2", 64'(g), 64'd4);
        get_frame(66, 2, 0, -1);
        check("sweep66_keep", 64'(cap_last_k), 64'h03);
        watch(10, dn, tv);
        check("sweep_done", 64'(dn), 64'd1);
        check("sweep_frames", 64'(w_fs), 64'd3);
        en = 1'b0; tick();

        // Zero IFG, max length 66: back-to-back frames and sweep wrap.
        sel = 1'b1; en2 = 1'b1;
        get_frame(64, 0, 0, -1);
        measure_gap(g);
        check("b2b_gap1", 64'(g), 64'd0);
        get_frame(65, 1, 0, -1);
        measure_gap(g);
        check("b2b_gap2", 64'(g), 64'd0);
        get_frame(66, 2, 0, -1);
        measure_gap(g);
        check("b2b_gap3", 64'(g), 64'd0);
        get_frame(64, 3, 0, 0);
        check("wrap_beats", 64'(cap_nbeats), 64'd8);
        check("b2b_stop", 64'(w_tv), 64'd0);
        check("b2b_frames", 64'(w_fs), 64'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
